// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one port of a 16x8 RAM between N requesters.
// Grants are combinational; read data returns one cycle after the grant with a per-requester valid.

module ram_port_arbiter #(
   parameter int unsigned N         = 4,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   input  logic [N-1:0]   lock,
   input  logic [N-1:0]   we,
   input  logic [4*N-1:0] addr,
   input  logic [8*N-1:0] wdata,
   output logic [N-1:0]   gnt,
   output logic [N-1:0]   rvalid,
   output logic [7:0]     rdata,
   output logic           mem_we,
   output logic [3:0]     mem_addr,
   output logic [7:0]     mem_wdata,
   input  logic [7:0]     mem_rdata
);

   localparam int unsigned IW       = (N > 1) ? $clog2(N) : 1;
   localparam logic [3:0]  MaxBurst = 4'(MAX_BURST);

   typedef logic [IW-1:0] idx_t;
   typedef enum logic [0:0] {StIdle, StOwned} state_e;

   state_e       state_q, state_d;
   idx_t         ptr_q, ptr_d;
   idx_t         owner_q, owner_d;
   logic [3:0]   burst_q, burst_d;
   logic [N-1:0] rvalid_q, rvalid_d;

   idx_t         scan_base, scan_idx, gnt_idx, sel_idx;
   logic         scan_hit, owner_req, gnt_any, others_wait;
   logic [3:0]   burst_inc;

   function automatic idx_t next_idx(input idx_t i);
      if (i == idx_t'(N - 1)) return '0;
      return idx_t'(i + 1'b1);
   endfunction

   function automatic idx_t wrap_add(input idx_t base, input int unsigned k);
      int unsigned s;
      s = 32'(base) + k;
      if (s >= N) s = s - N;
      return idx_t'(s);
   endfunction

   // Round-robin scan; while owned, the scan starts just past the owner so a
   // dropped owner hands over in the same cycle.
   always_comb begin
      scan_base = (state_q == StOwned) ? next_idx(owner_q) : ptr_q;
      scan_hit  = 1'b0;
      scan_idx  = '0;
      for (int k = int'(N) - 1; k >= 0; k--) begin
         if (req[wrap_add(scan_base, unsigned'(k))]) begin
            scan_hit = 1'b1;
            scan_idx = wrap_add(scan_base, unsigned'(k));
         end
      end
   end

   always_comb begin
      owner_req = (state_q == StOwned) && req[owner_q];
      gnt_any   = rst_n && (owner_req || scan_hit);
      gnt_idx   = owner_req ? owner_q : scan_idx;
      gnt       = '0;
      if (gnt_any) gnt[gnt_idx] = 1'b1;
      others_wait = |(req & ~gnt);
   end

   // With no grant the port shows requester 0's fields, but never writes.
   always_comb begin
      sel_idx   = gnt_any ? gnt_idx : '0;
      mem_we    = gnt_any && we[sel_idx];
      mem_addr  = rst_n ? addr[4*sel_idx +: 4] : 4'd0;
      mem_wdata = rst_n ? wdata[8*sel_idx +: 8] : 8'd0;
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      burst_d   = burst_q;
      burst_inc = (burst_q >= MaxBurst) ? MaxBurst : burst_q + 4'd1;
      rvalid_d  = gnt & ~we;

      unique case (state_q)
         StIdle: begin
            if (gnt_any) begin
               if (lock[gnt_idx] && !(MaxBurst == 4'd1 && others_wait)) begin
                  state_d = StOwned;
                  owner_d = gnt_idx;
                  burst_d = 4'd1;
               end else begin
                  ptr_d = next_idx(gnt_idx);
               end
            end
         end
         StOwned: begin
            if (owner_req) begin
               if (!lock[owner_q] || (burst_inc == MaxBurst && others_wait)) begin
                  state_d = StIdle;
                  ptr_d   = next_idx(owner_q);
                  burst_d = 4'd0;
               end else begin
                  burst_d = burst_inc;
               end
            end else begin
               state_d = StIdle;
               ptr_d   = next_idx(owner_q);
               burst_d = 4'd0;
               if (gnt_any) begin
                  if (lock[gnt_idx] && !(MaxBurst == 4'd1 && others_wait)) begin
                     state_d = StOwned;
                     owner_d = gnt_idx;
                     burst_d = 4'd1;
                  end else begin
                     ptr_d = next_idx(gnt_idx);
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         ptr_q    <= '0;
         owner_q  <= '0;
         burst_q  <= 4'd0;
         rvalid_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         burst_q  <= burst_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign rvalid = rvalid_q;
   assign rdata  = mem_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: vector table plus burst/reset sequences, read data via scoreboard.

module tb_ram_port_arbiter;

   localparam int unsigned N         = 4;
   localparam int unsigned MAX_BURST = 4;

   logic           clk;
   logic           rst_n;
   logic [N-1:0]   req, lock, we;
   logic [4*N-1:0] addr;
   logic [8*N-1:0] wdata;
   logic [N-1:0]   gnt, rvalid;
   logic [7:0]     rdata;
   logic           mem_we;
   logic [3:0]     mem_addr;
   logic [7:0]     mem_wdata;
   logic [7:0]     mem_rdata;

   ram_port_arbiter #(
      .N         (N),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .lock      (lock),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .gnt       (gnt),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM port with registered read data
   logic [7:0] ram [16];
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) ram[i] <= 8'd0;
         mem_rdata <= 8'd0;
      end else begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         mem_rdata <= ram[mem_addr];
      end
   end

   typedef struct {
      logic [N-1:0]   req;
      logic [N-1:0]   lock;
      logic [N-1:0]   we;
      logic [4*N-1:0] addr;
      logic [8*N-1:0] wdata;
      logic [N-1:0]   gnt;
   } vec_t;

   typedef struct {
      logic [N-1:0] rv;
      logic [7:0]   rd;
   } rd_exp_t;

   rd_exp_t    exp_q[$];
   logic [7:0] shadow [16];
   int         n_tests = 0;
   int         n_fail  = 0;
   vec_t       tbl [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [N-1:0] r, input logic [N-1:0] l,
                               input logic [N-1:0] w, input logic [4*N-1:0] a,
                               input logic [8*N-1:0] d, input logic [N-1:0] g);
      vec_t v;
      v.req = r; v.lock = l; v.we = w; v.addr = a; v.wdata = d; v.gnt = g;
      return v;
   endfunction

   task automatic clear_shadow();
      for (int i = 0; i < 16; i++) shadow[i] = 8'd0;
   endtask

   task automatic run_vec(input vec_t v);
      rd_exp_t    e;
      rd_exp_t    nx;
      int         gi;
      logic [3:0] a;
      @(posedge clk);
      #1;
      req = v.req; lock = v.lock; we = v.we; addr = v.addr; wdata = v.wdata;
      #3;
      e.rv = '0;
      e.rd = 8'd0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check("rvalid", 32'(rvalid), 32'(e.rv));
      if (e.rv != '0) check("rdata", 32'(rdata), 32'(e.rd));
      check("gnt", 32'(gnt), 32'(v.gnt));
      gi = -1;
      for (int i = 0; i < int'(N); i++) if (v.gnt[i]) gi = i;
      nx.rv = '0;
      nx.rd = 8'd0;
      if (gi >= 0) begin
         a = v.addr[4*gi +: 4];
         check("mem_we", 32'(mem_we), 32'(v.we[gi]));
         check("mem_addr", 32'(mem_addr), 32'(a));
         if (v.we[gi]) begin
            check("mem_wdata", 32'(mem_wdata), 32'(v.wdata[8*gi +: 8]));
            shadow[a] = v.wdata[8*gi +: 8];
         end else begin
            nx.rv = v.gnt;
            nx.rd = shadow[a];
         end
      end else begin
         check("mem_we_idle", 32'(mem_we), 32'd0);
      end
      exp_q.push_back(nx);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Single write/read, then full round-robin, then write-then-read across requesters
      tbl[0]  = mk(4'b0001, 4'b0000, 4'b0001, 16'h0003, 32'h0000_00A5, 4'b0001);
      tbl[1]  = mk(4'b0001, 4'b0000, 4'b0000, 16'h0003, 32'h0,         4'b0001);
      tbl[2]  = mk(4'b0000, 4'b0000, 4'b0000, 16'h0000, 32'h0,         4'b0000);
      tbl[3]  = mk(4'b1000, 4'b0000, 4'b1000, 16'h7000, 32'h5A00_0000, 4'b1000);
      tbl[4]  = mk(4'b1111, 4'b0000, 4'b0000, 16'h7123, 32'h0,         4'b0001);
      tbl[5]  = mk(4'b1111, 4'b0000, 4'b0000, 16'h7123, 32'h0,         4'b0010);
      tbl[6]  = mk(4'b1111, 4'b0000, 4'b0000, 16'h7123, 32'h0,         4'b0100);
      tbl[7]  = mk(4'b1111, 4'b0000, 4'b0000, 16'h7123, 32'h0,         4'b1000);
      tbl[8]  = mk(4'b1111, 4'b0000, 4'b0000, 16'h7123, 32'h0,         4'b0001);
      tbl[9]  = mk(4'b0001, 4'b0000, 4'b0001, 16'h000F, 32'h0000_003C, 4'b0001);
      tbl[10] = mk(4'b0100, 4'b0000, 4'b0000, 16'h0F00, 32'h0,         4'b0100);
      tbl[11] = mk(4'b0000, 4'b0000, 4'b0000, 16'h0000, 32'h0,         4'b0000);

      clear_shadow();
      rst_n = 1'b0;
      req = '1; lock = '1; we = '1; addr = '1; wdata = '1;
      #2;
      check("reset_gnt", 32'(gnt), 32'd0);
      check("reset_rvalid", 32'(rvalid), 32'd0);
      check("reset_mem_we", 32'(mem_we), 32'd0);
      check("reset_mem_addr", 32'(mem_addr), 32'd0);
      check("reset_mem_wdata", 32'(mem_wdata), 32'd0);
      repeat (2) @(posedge clk);
      #2;
      check("reset_rdata", 32'(rdata), 32'(mem_rdata));
      req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
      rst_n = 1'b1;

      foreach (tbl[i]) run_vec(tbl[i]);

      // Locked burst capped at MAX_BURST while requester 2 waits
      repeat (4) run_vec(mk(4'b0110, 4'b0010, 4'b0000, 16'h0F30, 32'h0, 4'b0010));
      run_vec(mk(4'b0110, 4'b0010, 4'b0000, 16'h0F30, 32'h0, 4'b0100));
      run_vec(mk(4'b0000, 4'b0000, 4'b0000, 16'h0000, 32'h0, 4'b0000));

      // Lone locked owner keeps the port past the cap, yields one grant after req[3] rises
      repeat (7) run_vec(mk(4'b0010, 4'b0010, 4'b0000, 16'h7F30, 32'h0, 4'b0010));
      run_vec(mk(4'b1010, 4'b0010, 4'b0000, 16'h7F30, 32'h0, 4'b0010));
      run_vec(mk(4'b1010, 4'b0010, 4'b0000, 16'h7F30, 32'h0, 4'b1000));
      run_vec(mk(4'b0000, 4'b0000, 4'b0000, 16'h0000, 32'h0, 4'b0000));

      // Unlock at the grant, and owner dropping its request
      run_vec(mk(4'b0010, 4'b0010, 4'b0000, 16'h7F30, 32'h0, 4'b0010));
      run_vec(mk(4'b1010, 4'b0000, 4'b0000, 16'h7F30, 32'h0, 4'b0010));
      run_vec(mk(4'b1010, 4'b0000, 4'b0000, 16'h7F30, 32'h0, 4'b1000));
      run_vec(mk(4'b0100, 4'b0100, 4'b0000, 16'h7F30, 32'h0, 4'b0100));
      run_vec(mk(4'b0001, 4'b0000, 4'b0000, 16'h7F30, 32'h0, 4'b0001));
      run_vec(mk(4'b0000, 4'b0000, 4'b0000, 16'h0000, 32'h0, 4'b0000));

      // Reset mid-burst with a read in flight
      run_vec(mk(4'b0100, 4'b0000, 4'b0000, 16'h0F30, 32'h0, 4'b0100));
      run_vec(mk(4'b0010, 4'b0010, 4'b0000, 16'h0F30, 32'h0, 4'b0010));
      run_vec(mk(4'b0010, 4'b0010, 4'b0000, 16'h0F30, 32'h0, 4'b0010));
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_gnt", 32'(gnt), 32'd0);
      check("midrst_rvalid", 32'(rvalid), 32'd0);
      check("midrst_mem_we", 32'(mem_we), 32'd0);
      req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
      exp_q.delete();
      clear_shadow();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      run_vec(mk(4'b1100, 4'b0000, 4'b0000, 16'h7F00, 32'h0, 4'b0100));
      run_vec(mk(4'b1000, 4'b0000, 4'b0000, 16'h7F00, 32'h0, 4'b1000));
      run_vec(mk(4'b0000, 4'b0000, 4'b0000, 16'h0000, 32'h0, 4'b0000));
      run_vec(mk(4'b0000, 4'b0000, 4'b0000, 16'h0000, 32'h0, 4'b0000));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
